// File: rtl/step_segment_sequencer.sv
// Step segment sequencer: buffers {reduction, count, dir} segments from the
// host side and launches them one at a time on a single-axis step pulse
// generator, enforcing DIR setup time and a guard window that masks a stale
// finish flag right after each start strobe.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no active segment; pops the FIFO head when run is high
// SETUP | direction just changed; holding DIR before the start strobe
// START | one-cycle gen_start strobe to the generator
// GUARD | gen_finish ignored while the generator clears its done flag
// RUN   | waiting for gen_finish to close out the segment
module step_segment_sequencer #(
  parameter int DEPTH     = 8,
  parameter int DIR_SETUP = 4,
  parameter int GUARD     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_reduction,
  input  logic [30:0]              cmd_count,
  input  logic                     cmd_dir,
  input  logic                     run,
  input  logic                     abort,
  output logic                     gen_start,
  output logic [31:0]              gen_reduction,
  output logic [30:0]              gen_count,
  input  logic                     gen_finish,
  output logic                     dir,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     seg_done,
  output logic [15:0]              seg_total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_GUARD,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     gen_red_q, gen_red_d;
  logic [30:0]     gen_cnt_q, gen_cnt_d;
  logic            dir_q, dir_d;
  logic            seg_done_q, seg_done_d;
  logic [15:0]     seg_total_q, seg_total_d;

  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [63:0]     mem_q [DEPTH];
  logic [AW:0]     level_w;
  logic            full, empty, push, pop;
  logic [63:0]     head;
  logic [31:0]     push_red;

  assign level_w   = wr_ptr_q - rd_ptr_q;
  assign full      = (level_w == (AW+1)'(DEPTH));
  assign empty     = (level_w == '0);
  assign cmd_ready = !reset && !full && !abort;
  assign push      = cmd_valid && cmd_ready;
  // An abort in the same cycle flushes the queue, so the head is not launched.
  assign pop       = (state_q == S_IDLE) && run && !empty && !abort;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign push_red  = (cmd_reduction == 32'd0) ? 32'd1 : cmd_reduction;

  // Segment storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {push_red, cmd_count, cmd_dir};
    end
  end

  // FIFO pointers; abort empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gen_red_q   <= '0;
      gen_cnt_q   <= '0;
      dir_q       <= 1'b0;
      seg_done_q  <= 1'b0;
      seg_total_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gen_red_q   <= gen_red_d;
      gen_cnt_q   <= gen_cnt_d;
      dir_q       <= dir_d;
      seg_done_q  <= seg_done_d;
      seg_total_q <= seg_total_d;
    end
  end

  // Next-state logic; the generator cannot be cancelled once started, so
  // only SETUP reacts to abort.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gen_red_d   = gen_red_q;
    gen_cnt_d   = gen_cnt_q;
    dir_d       = dir_q;
    seg_done_d  = 1'b0;
    seg_total_d = seg_total_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          gen_red_d = head[63:32];
          gen_cnt_d = head[31:1];
          if (head[0] != dir_q) begin
            dir_d   = head[0];
            cnt_d   = CW'(DIR_SETUP - 1);
            state_d = S_SETUP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_SETUP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_START: begin
        cnt_d   = CW'(GUARD - 1);
        state_d = S_GUARD;
      end
      S_GUARD: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (gen_finish) begin
          state_d     = S_IDLE;
          seg_done_d  = 1'b1;
          seg_total_d = seg_total_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gen_start     = (state_q == S_START);
  assign gen_reduction = gen_red_q;
  assign gen_count     = gen_cnt_q;
  assign dir           = dir_q;
  assign busy          = (state_q != S_IDLE) || !empty;
  assign level         = level_w;
  assign seg_done      = seg_done_q;
  assign seg_total     = seg_total_q;

endmodule

// File: tb/tb_step_segment_sequencer.sv
module tb_step_segment_sequencer;
  localparam int DEPTH     = 8;
  localparam int DIR_SETUP = 4;
  localparam int GUARD     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_reduction = '0;
  logic [30:0] cmd_count = '0;
  logic        cmd_dir = 1'b0;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic        gen_start;
  logic [31:0] gen_reduction;
  logic [30:0] gen_count;
  logic        gen_finish;
  logic        dir;
  logic        busy;
  logic [3:0]  level;
  logic        seg_done;
  logic [15:0] seg_total;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_total = 0;

  step_segment_sequencer #(.DEPTH(DEPTH), .DIR_SETUP(DIR_SETUP), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reduction(cmd_reduction), .cmd_count(cmd_count), .cmd_dir(cmd_dir),
    .run(run), .abort(abort), .gen_start(gen_start), .gen_reduction(gen_reduction),
    .gen_count(gen_count), .gen_finish(gen_finish), .dir(dir), .busy(busy),
    .level(level), .seg_done(seg_done), .seg_total(seg_total)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Generator model: done flag drops after the start strobe, rises 2*count cycles later.
  logic force_fin = 1'b0;
  logic gen_busy = 1'b0;
  int   gen_left = 0;
  always @(posedge clk) begin
    if (reset) begin
      gen_busy <= 1'b0;
      gen_left <= 0;
    end else if (gen_start) begin
      gen_busy <= 1'b1;
      gen_left <= 2 * int'(gen_count);
    end else if (gen_busy) begin
      if (gen_left <= 1) gen_busy <= 1'b0;
      gen_left <= gen_left - 1;
    end
  end
  assign gen_finish = force_fin | ~gen_busy;

  // Event monitor, sampled on the falling edge.
  int start_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;
  int dir_chg_cyc = 0, drop_cyc = 0, done_total = 0;
  logic [31:0] st_red;
  logic [30:0] st_cnt;
  logic        st_dir;
  logic        prev_dir = 1'b0;
  logic [3:0]  prev_level = '0;
  logic [31:0] red_q[$];
  int start_q[$], done_q[$], drop_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (gen_start) begin
        start_cnt++;
        start_cyc = cyc;
        st_red = gen_reduction;
        st_cnt = gen_count;
        st_dir = dir;
        red_q.push_back(gen_reduction);
        start_q.push_back(cyc);
      end
      if (seg_done) begin
        done_cnt++;
        done_cyc = cyc;
        done_total = int'(seg_total);
        done_q.push_back(cyc);
      end
      if (dir !== prev_dir) dir_chg_cyc = cyc;
      if (level < prev_level) begin
        drop_cyc = cyc;
        drop_q.push_back(cyc);
      end
    end
    prev_dir = dir;
    prev_level = level;
  end

  task automatic clear_logs();
    red_q.delete();
    start_q.delete();
    done_q.delete();
    drop_q.delete();
  endtask

  task automatic push(input logic [31:0] r, input logic [30:0] c, input logic d, output bit acc);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_reduction = r;
    cmd_count = c;
    cmd_dir = d;
    #1 acc = cmd_ready;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #1 n++;
    end
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s_timeout: seg_done count %0d, required %0d", nm, done_cnt, target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    checks++; if (gen_start !== 1'b0 || gen_reduction !== 32'd0 || gen_count !== 31'd0) begin
      errors++; $display("FAIL reset_gen: start %b red %0d cnt %0d want 0/0/0", gen_start, gen_reduction, gen_count); end
    checks++; if (dir !== 1'b0 || busy !== 1'b0 || seg_done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: dir %b busy %b done %b want 0", dir, busy, seg_done); end
    checks++; if (level !== 4'd0 || seg_total !== 16'd0) begin
      errors++; $display("FAIL reset_counts: level %0d total %0d want 0", level, seg_total); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single();
    bit acc;
    int s0 = start_cnt, d0 = done_cnt;
    clear_logs();
    push(32'd3, 31'd2, 1'b0, acc);
    #1;
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", level); end
    @(negedge clk);
    run = 1'b1;
    wait_done(d0 + 1, 60, "single");
    repeat (3) @(negedge clk);
    #1;
    exp_total = 1;
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
    checks++; if (st_red !== 32'd3 || st_cnt !== 31'd2) begin
      errors++; $display("FAIL single_strobe_vals: red %0d cnt %0d want 3/2", st_red, st_cnt); end
    checks++; if (start_cyc - drop_cyc !== 0) begin
      errors++; $display("FAIL single_start_latency: got %0d want 0", start_cyc - drop_cyc); end
    checks++; if (done_cnt - d0 !== 1 || seg_total !== 16'(exp_total)) begin
      errors++; $display("FAIL single_done: pulses %0d total %0d want 1/%0d", done_cnt - d0, seg_total, exp_total); end
    checks++; if (busy !== 1'b0 || gen_reduction !== 32'd3) begin
      errors++; $display("FAIL single_idle: busy %b red %0d want 0/3", busy, gen_reduction); end
    run = 1'b0;
  endtask

  task automatic test_dir_change();
    bit acc;
    int d0 = done_cnt;
    clear_logs();
    push(32'd5, 31'd1, 1'b0, acc);
    push(32'd5, 31'd1, 1'b1, acc);
    @(negedge clk);
    run = 1'b1;
    wait_done(d0 + 2, 80, "dir");
    exp_total = 3;
    checks++; if (start_q.size() != 2 || start_q[0] !== drop_q[0]) begin
      errors++; $display("FAIL dir_first_no_setup: starts %0d, first start %0d want %0d", start_q.size(),
                         (start_q.size() > 0) ? start_q[0] : -1, (drop_q.size() > 0) ? drop_q[0] : -1); end
    checks++; if (start_cyc - drop_cyc !== DIR_SETUP) begin
      errors++; $display("FAIL dir_setup_len: got %0d want %0d", start_cyc - drop_cyc, DIR_SETUP); end
    checks++; if (dir_chg_cyc !== drop_cyc || st_dir !== 1'b1) begin
      errors++; $display("FAIL dir_toggle: toggle %0d pop+1 %0d dir_at_start %b want 1", dir_chg_cyc, drop_cyc, st_dir); end
    checks++; if (seg_total !== 16'(exp_total)) begin
      errors++; $display("FAIL dir_total: got %0d want %0d", seg_total, exp_total); end
    run = 1'b0;
  endtask

  task automatic test_full();
    bit acc;
    int n_acc = 0, d0;
    bit order_ok = 1'b1;
    @(negedge clk);
    clear_logs();
    d0 = done_cnt;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(32'(10 + i), 31'd1, 1'b1, acc);
      if (acc) n_acc++;
    end
    #1;
    checks++; if (n_acc !== DEPTH) begin errors++; $display("FAIL full_accepts: got %0d want %0d", n_acc, DEPTH); end
    checks++; if (level !== 4'(DEPTH) || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL full_backpressure: level %0d ready %b want %0d/0", level, cmd_ready, DEPTH); end
    @(negedge clk);
    run = 1'b1;
    wait_done(d0 + DEPTH, 400, "full");
    repeat (2) @(negedge clk);
    #1;
    exp_total = 3 + DEPTH;
    if (red_q.size() != DEPTH) order_ok = 1'b0;
    else for (int i = 0; i < DEPTH; i++) if (red_q[i] !== 32'(10 + i)) order_ok = 1'b0;
    checks++; if (!order_ok) begin errors++; $display("FAIL full_order: %0d launches, order wrong, want %0d in order", red_q.size(), DEPTH); end
    checks++; if (seg_total !== 16'(exp_total) || busy !== 1'b0) begin
      errors++; $display("FAIL full_drain: total %0d busy %b want %0d/0", seg_total, busy, exp_total); end
    run = 1'b0;
  endtask

  task automatic test_guard();
    bit acc;
    int d0 = done_cnt;
    clear_logs();
    force_fin = 1'b1;
    push(32'd2, 31'd1, 1'b1, acc);
    push(32'd2, 31'd1, 1'b1, acc);
    @(negedge clk);
    run = 1'b1;
    wait_done(d0 + 2, 60, "guard");
    force_fin = 1'b0;
    exp_total = 5 + DEPTH;
    if (start_q.size() == 2 && done_q.size() == 2 && drop_q.size() == 2) begin
      checks++; if (done_q[0] - drop_q[0] !== GUARD + 2) begin
        errors++; $display("FAIL guard_seg1_len: got %0d want %0d", done_q[0] - drop_q[0], GUARD + 2); end
      checks++; if (done_q[1] - start_q[1] !== GUARD + 2) begin
        errors++; $display("FAIL guard_seg2_len: got %0d want %0d", done_q[1] - start_q[1], GUARD + 2); end
      checks++; if (start_q[1] - done_q[0] !== 1) begin
        errors++; $display("FAIL back_to_back: got %0d want 1", start_q[1] - done_q[0]); end
    end else begin
      checks++; errors++;
      $display("FAIL guard_events: starts %0d dones %0d pops %0d want 2/2/2", start_q.size(), done_q.size(), drop_q.size());
    end
    run = 1'b0;
  endtask

  task automatic test_abort();
    bit acc;
    int s0, d0, n = 0;
    for (int i = 0; i < 4; i++) push(32'd4, 31'd3, 1'b1, acc);
    s0 = start_cnt;
    d0 = done_cnt;
    @(negedge clk);
    run = 1'b1;
    while (start_cnt == s0 && n < 20) begin @(negedge clk); #1 n++; end
    repeat (GUARD + 1) @(negedge clk);
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_reduction = 32'd9;
    cmd_count = 31'd1;
    cmd_dir = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_block: ready %b busy %b want 0/1", cmd_ready, busy); end
    @(negedge clk);
    abort = 1'b0;
    cmd_valid = 1'b0;
    #1;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL abort_flush: level %0d want 0", level); end
    wait_done(d0 + 1, 40, "abort");
    repeat (20) @(negedge clk);
    #1;
    exp_total = 6 + DEPTH;
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL abort_no_restart: starts %0d want 1", start_cnt - s0); end
    checks++; if (seg_total !== 16'(exp_total) || busy !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL abort_end: total %0d busy %b level %0d want %0d/0/0", seg_total, busy, level, exp_total); end
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit acc;
    int s0 = start_cnt, d0, n = 0;
    push(32'd3, 31'd5, 1'b1, acc);
    @(negedge clk);
    run = 1'b1;
    while (start_cnt == s0 && n < 20) begin @(negedge clk); #1 n++; end
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (seg_done !== 1'b0 || seg_total !== 16'd0 || busy !== 1'b0 || dir !== 1'b0) begin
      errors++; $display("FAIL reset_mid: done %b total %0d busy %b dir %b want 0", seg_done, seg_total, busy, dir); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (done_cnt !== d0 || seg_total !== 16'd0) begin
      errors++; $display("FAIL reset_mid_no_done: pulses %0d total %0d want 0/0", done_cnt - d0, seg_total); end
  endtask

  task automatic test_clamp_wrap();
    bit acc;
    int d0 = done_cnt;
    push(32'd0, 31'd2, 1'b0, acc);
    @(negedge clk);
    force dut.seg_total_q = 16'hFFFF;
    @(negedge clk);
    release dut.seg_total_q;
    run = 1'b1;
    wait_done(d0 + 1, 40, "clamp");
    checks++; if (st_red !== 32'd1) begin errors++; $display("FAIL clamp: gen_reduction %0d want 1", st_red); end
    checks++; if (done_total !== 0) begin errors++; $display("FAIL wrap: seg_total %0d want 0", done_total); end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dir_change();
    test_full();
    test_guard();
    test_abort();
    test_reset_mid();
    test_clamp_wrap();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/step_segment_sequencer.md
# step_segment_sequencer

Queues step segments (divider, pulse count, direction) written by the HPS bridge and launches them one at a time on a single-axis step pulse generator. For each segment it drives the generator's start/reset strobe, divider and count. It holds DIR stable for a setup window before the first edge and waits for the generator's finish flag before launching the next segment. One instance sits between the Avalon-side command registers and each axis' pulse generator.

## Interface
- DEPTH, 8: segment FIFO depth; must be a power of 2, ≥2.
- DIR_SETUP, 4: clk cycles DIR must be stable before gen_start when direction changes; ≥1.
- GUARD, 2: clk cycles after gen_start during which gen_finish is ignored; ≥1.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  segment offered.
- cmd_ready  out  1  segment accepted when cmd_valid && cmd_ready.
- cmd_reduction  in  32  clk cycles per step half-period.
- cmd_count  in  31  step count for the segment.
- cmd_dir  in  1  direction for the segment.
- run  in  1  launch enable; low pauses between segments.
- abort  in  1  flush queued segments.
- gen_start  out  1  one-cycle start strobe to the generator's reset input.
- gen_reduction  out  32  divider presented to the generator.
- gen_count  out  31  count presented to the generator.
- gen_finish  in  1  generator done flag, level.
- dir  out  1  axis direction pin.
- busy  out  1  state≠IDLE or FIFO non-empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- seg_done  out  1  one-cycle pulse per completed segment.
- seg_total  out  16  completed-segment counter.

## Operation
- FIFO entries are {reduction, count, dir}. cmd_reduction==0 is clamped to 1 on push.
- cmd_ready = !full && !abort. There is no full-FIFO pass-through, so a push and a pop in the same cycle are only possible when not full.
- FSM states: IDLE, SETUP, START, GUARD, RUN. All outputs are registered or decoded from the state register.
- IDLE:
  - If run && level≠0, pop the head.
  - The popped reduction and count load into gen_reduction and gen_count.
  - If the head dir ≠ the current dir, update dir, load the setup counter with DIR_SETUP and go to SETUP. Otherwise go to START.
- SETUP: count down DIR_SETUP cycles, then go to START. If abort is asserted, drop the popped segment and return to IDLE; dir keeps its new value.
- START: gen_start=1 for exactly this one cycle, then go to GUARD.
- GUARD: stay GUARD cycles, ignoring gen_finish, then go to RUN.
- RUN: when gen_finish==1 is sampled, go to IDLE, pulse seg_done and increment seg_total (wraps 0xFFFF→0).
- abort:
  - Same cycle: clears the FIFO (level=0 next cycle) and blocks any push.
  - Segments in START, GUARD or RUN run to completion, because the generator cannot be cancelled.
- run low never interrupts an active segment; it only blocks the IDLE pop.
- gen_reduction and gen_count hold their last values while in IDLE.

## Timing
- Reset values:
  - state=IDLE, FIFO empty, level=0.
  - cmd_ready=0 during reset, 1 the first cycle after.
  - gen_start=0, gen_reduction=0, gen_count=0.
  - dir=0, busy=0, seg_done=0, seg_total=0.
- Reset mid-segment: the FSM returns to IDLE, no seg_done pulse is issued and seg_total clears.
- Pushed at cycle P: level is updated at P+1; the entry is poppable at P+1.
- Pop at IDLE cycle T, same dir:
  - gen_start is high in T+1.
  - GUARD spans T+2..T+1+GUARD.
  - RUN starts at T+2+GUARD.
- Pop at cycle T, dir change:
  - dir toggles at T+1.
  - SETUP spans T+1..T+DIR_SETUP.
  - gen_start is high in T+DIR_SETUP+1.
- gen_reduction and gen_count are valid from T+1, at or before gen_start, and stable through RUN.
- gen_finish sampled high in RUN at cycle F: seg_done=1 and seg_total+1 in F+1, state=IDLE in F+1; the next pop can occur in F+1.
- A new gen_start is never issued while in RUN.

## Test plan
- Single segment: reduction=3, count=2, dir=0 from reset, run=1, model generator → exactly one gen_start; gen_reduction=3 and gen_count=2 at the strobe; seg_done once; seg_total=1; busy low afterwards.
- Direction change: push {5,1,0} then {5,1,1} → second gen_start occurs exactly DIR_SETUP+1 cycles after its pop; dir=1 throughout those DIR_SETUP cycles.
- Full/backpressure: push DEPTH+2 segments with run=0 → cmd_ready low at level=DEPTH; extra pushes not accepted; raising run drains all DEPTH in order with seg_total=DEPTH.
- Guard/stale finish: hold gen_finish=1 continuously → each segment still spends GUARD cycles before RUN; segments do not complete sooner than 2+GUARD cycles after pop.
- Abort: 4 queued, abort asserted during RUN of the first → level=0 next cycle; current segment completes with seg_done; no further gen_start; push attempted during abort is rejected.
- Clamp and wrap: push reduction=0 → gen_reduction=1; preload 65535 completions → next seg_done wraps seg_total to 0.
